// File: rtl/digit_scan_driver.sv
// digit_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   A prescaler divides each digit slot into TICK_DIV cycles. The first
//   BLANK_CYCLES of every slot force segments/dp off to kill ghosting. The
//   16-bit value and dp requests are snapshotted once per frame, on the
//   edge that returns digit_sel to 0, so a frame never mixes two values.
//
//   Optional feature (compile-time macro): LEADING_ZERO_BLANK_EN
//     When defined, digits 3..1 are blanked in SHOW if their nibble and all
//     higher nibbles of the snapshot are zero. dp is not affected.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   value      : four hex digits, [3:0] = digit 0 (rightmost)
//   dp_in      : decimal-point request per digit, active-high
//   digit_sel  : index of the lit digit, feeds the 2-to-4 anode decoder
//   segments   : active-low {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   frame_load : one-cycle pulse in the cycle after value/dp_in are captured
module digit_scan_driver #(
  parameter int TICK_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [1:0]  digit_sel,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_load
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);

  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      sel_nx;
  logic [15:0]     sh_val, sh_val_nx;
  logic [3:0]      sh_dp, sh_dp_nx;
  logic [3:0][3:0] nibs;
  logic            wrap, frame_edge, blank, lead_zero;
  logic [6:0]      seg_nx;
  logic            dp_nx;

  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap       = (cnt == CNT_MAX);
  assign frame_edge = wrap && (digit_sel == 2'd3);
  assign cnt_nx     = wrap ? '0 : cnt + 1'b1;
  assign sel_nx     = wrap ? digit_sel + 2'd1 : digit_sel;
  assign sh_val_nx  = frame_edge ? value : sh_val;
  assign sh_dp_nx   = frame_edge ? dp_in : sh_dp;

  // Outputs are registered from the next-state view, so the new anode and
  // its blank (or its new pattern when there is no blank) land on one edge.
  assign nibs  = sh_val_nx;
  assign blank = (cnt_nx < BLANK_W);

`ifdef LEADING_ZERO_BLANK_EN
  // Everything from this digit upward is zero; digit 0 is never suppressed.
  assign lead_zero = (sel_nx != 2'd0) && ((sh_val_nx >> {sel_nx, 2'b00}) == 16'd0);
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    seg_nx = 7'h7F;
    dp_nx  = 1'b1;
    if (!blank) begin
      seg_nx = lead_zero ? 7'h7F : hex7seg(nibs[sel_nx]);
      dp_nx  = ~sh_dp_nx[sel_nx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      digit_sel  <= 2'd0;
      sh_val     <= 16'd0;
      sh_dp      <= 4'd0;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_load <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      digit_sel  <= sel_nx;
      sh_val     <= sh_val_nx;
      sh_dp      <= sh_dp_nx;
      segments   <= seg_nx;
      dp         <= dp_nx;
      frame_load <= frame_edge;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver (TICK_DIV = 8, BLANK_CYCLES = 2).
// A cycle-count model derives the expected outputs every cycle; directed
// frames with literal patterns pin that model.
module tb_digit_scan_driver;
  localparam int T  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * T;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [1:0]  digit_sel;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_load;

  digit_scan_driver #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in),
    .digit_sel(digit_sel), .segments(segments), .dp(dp), .frame_load(frame_load)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int prints = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: n = rising edges since reset release; snapshot taken every FR edges.
  int          n = 0;
  logic [15:0] msh = 16'd0;
  logic [3:0]  mdp = 4'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n = 0; msh = 16'd0; mdp = 4'd0;
    end else begin
      n = n + 1;
      if (n % FR == 0) begin msh = value; mdp = dp_in; end
    end
  end

  always @(negedge clk) begin
    logic [1:0] es;
    logic [6:0] eseg;
    logic       edp, efl;
    int         c;
    es = 2'd0; eseg = 7'h7F; edp = 1'b1; efl = 1'b0;
    if (reset_n) begin
      c   = n % T;
      es  = 2'((n / T) % 4);
      efl = (n > 0) && (n % FR == 0);
      if (c >= B) begin
        eseg = HEX[(msh >> (4 * es)) & 16'hF];
`ifdef LEADING_ZERO_BLANK_EN
        if (es != 0 && (msh >> (4 * es)) == 0) eseg = 7'h7F;
`endif
        edp = ~mdp[es];
      end
    end
    n_chk++;
    if ({digit_sel, segments, dp, frame_load} !== {es, eseg, edp, efl}) begin
      n_fail++;
      if (prints < 20) begin
        prints++;
        $display("FAIL model n=%0d: got sel=%0d seg=%h dp=%b fl=%b, expected sel=%0d seg=%h dp=%b fl=%b",
                 n, digit_sel, segments, dp, frame_load, es, eseg, edp, efl);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [6:0] cs   [FR];
  logic       cd   [FR];
  logic [1:0] csel [FR];

  // Sample one frame, one sample per cycle, optionally changing value mid-way.
  task automatic capture(input int chg_at, input logic [15:0] chg_val);
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      cs[i] = segments; cd[i] = dp; csel[i] = digit_sel;
      if (i == chg_at) value = chg_val;
    end
  endtask

  task automatic check_frame(input string nm, input logic [3:0][6:0] ep, input logic [3:0] edp);
    for (int i = 0; i < FR; i++) begin
      int k, j;
      k = i / T; j = i % T;
      chk($sformatf("%s cyc%0d {sel,seg,dp}", nm, i), {csel[i], cs[i], cd[i]},
          {2'(k), (j < B) ? 7'h7F : ep[k], (j < B) ? 1'b1 : ~edp[k]});
    end
  endtask

  task automatic wait_fl(input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!frame_load && k < 200);
    chk({nm, " frame_load seen"}, frame_load, 1'b1);
  endtask

  initial begin
    value = 16'h1234; dp_in = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset sel", digit_sel, 2'd0);
    chk("reset seg", segments, 7'h7F);
    chk("reset dp", dp, 1'b1);
    chk("reset fl", frame_load, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    capture(-1, 16'd0);
    check_frame("frame0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'd0);
    wait_fl("1234");
    capture(-1, 16'd0);
    check_frame("1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'd0);

    value = 16'hA0F8; dp_in = 4'b0100;
    wait_fl("A0F8");
    capture(-1, 16'd0);
    check_frame("A0F8", {7'h08, 7'h40, 7'h0E, 7'h00}, 4'b0100);

    value = 16'h1111; dp_in = 4'd0;
    wait_fl("1111");
    capture(T + 3, 16'h2222);
    check_frame("1111 mid change", {7'h79, 7'h79, 7'h79, 7'h79}, 4'd0);
    wait_fl("2222");
    capture(-1, 16'd0);
    check_frame("2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'd0);

    // Reset while digit 2 is in SHOW; outputs must drop without a clock.
    wait_fl("pre-reset");
    repeat (2 * T + 4) @(negedge clk);
    #1;
    chk("pre-reset show", {digit_sel, segments}, {2'd2, 7'h24});
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset seg", segments, 7'h7F);
    chk("async reset dp", dp, 1'b1);
    chk("async reset sel", digit_sel, 2'd0);
    chk("async reset fl", frame_load, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    capture(-1, 16'd0);
    check_frame("post-reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'd0);

    value = 16'h0050; dp_in = 4'b1000;
    wait_fl("0050");
    capture(-1, 16'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("0050 lzb", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1000);
    value = 16'h0000; dp_in = 4'd0;
    wait_fl("0000");
    capture(-1, 16'd0);
    check_frame("0000 lzb", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'd0);
`else
    check_frame("0050", {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1000);
`endif

    // Free run with random inputs; frame_load spacing must be one frame.
    begin
      int q[$];
      for (int i = 0; i < 3 * FR + 8; i++) begin
        @(negedge clk);
        #1;
        if (frame_load) q.push_back(i);
        if (i % 5 == 0) begin value = 16'($urandom); dp_in = 4'($urandom); end
      end
      chk("fl pulse count", (q.size() >= 3), 1'b1);
      for (int i = 1; i < q.size(); i++)
        chk($sformatf("fl period %0d", i), q[i] - q[i-1], FR);
    end

    // Longer random run checked only by the per-cycle model.
    for (int i = 0; i < 40 * FR; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 6) == 0) begin value = 16'($urandom); dp_in = 4'($urandom); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_driver.md
# digit_scan_driver

Time-multiplexed driver for the board's 4-digit, common-anode 7-segment display. It cycles a 2-bit digit index that feeds the existing 2-to-4 anode decoder, so exactly one anode is low at a time. For each slot it drives the active-low segment and decimal-point lines for the matching hex nibble of a 16-bit value. The value is snapshotted once per frame so the display never tears, and a short blanking interval at the start of each slot suppresses ghosting.

## Interface
- TICK_DIV, 100_000: clock cycles per digit slot (100 MHz → 1 kHz per digit); legal range ≥ 2.
- BLANK_CYCLES, 1_000: cycles at the start of each slot with segments and dp forced off; legal range 0 ≤ BLANK_CYCLES < TICK_DIV.
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- value  input  16  four hex digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- dp_in  input  4  decimal-point request per digit, active-high; bit k → digit k.
- digit_sel  output  2  index of the digit currently lit; drives the anode decoder (0 → anodes 1110).
- segments  output  7  active-low {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_load  output  1  one-cycle pulse when value/dp_in are captured.

## Operation
- Prescaler cnt counts 0 … TICK_DIV-1 and then wraps to 0. On each wrap, digit_sel advances 0→1→2→3→0.
- Shadow registers: shadow_val[15:0] and shadow_dp[3:0].
  - Both load from value and dp_in on the edge where cnt = TICK_DIV-1 and digit_sel = 3, i.e. the same edge on which digit_sel goes to 0.
  - frame_load is high for exactly the cycle after that edge.
  - Input changes at any other time have no visible effect until the next frame boundary.
- Slot phases, driven by cnt:
  - BLANK (cnt < BLANK_CYCLES): segments = 7'h7F, dp = 1.
  - SHOW (cnt ≥ BLANK_CYCLES): segments = hex7seg(shadow_val nibble[digit_sel]), dp = ~shadow_dp[digit_sel].
- Hex encoding, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset (asynchronous assert, synchronous release by clk):
  - cnt = 0, digit_sel = 0, shadow_val = 0, shadow_dp = 0.
  - segments = 7'h7F, dp = 1, frame_load = 0.
  - The first frame after reset shows "0000" with no dp, because the shadow holds 0 until the first boundary.
- Reset mid-slot: all outputs go to their reset values immediately, with no clock needed. The display restarts at digit 0 in BLANK.

## Timing
- All outputs are registered. digit_sel, segments, dp and frame_load change only on rising clk edges.
- digit_sel and the switch of segments to 7'h7F occur on the same edge. There is never a cycle in which a new anode shows the previous digit's segments.
- Each slot lasts exactly TICK_DIV cycles: BLANK_CYCLES blank, then TICK_DIV - BLANK_CYCLES shown. A frame is 4·TICK_DIV cycles.
- BLANK_CYCLES = 0: segments switch directly to the new digit's pattern on the digit_sel edge.
- Latency from a value change to display: it appears in the frame following the next frame boundary. Worst case is 4·TICK_DIV + BLANK_CYCLES + 1 cycles.
- frame_load period is exactly 4·TICK_DIV cycles.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: in SHOW, digit k (k = 3, 2, 1) outputs segments = 7'h7F if its shadow nibble and all higher shadow nibbles are zero. Digit 0 is always shown. dp is unaffected; a blanked digit with shadow_dp set still lights its dp.
  - Undefined: all four digits always show their nibble, including leading zeros.

## Test plan
Bench parameters: TICK_DIV = 8, BLANK_CYCLES = 2.
- Reset, then value = 16'h1234, dp_in = 0. Required:
  - Frame 0 shows 40 on every digit.
  - From the first frame_load on, digit_sel sequence is 0,1,2,3, with segments after blank = 19, 30, 24, 79 (nibbles 4, 3, 2, 1).
  - Each slot is 2 cycles at 7F, then 6 cycles at the pattern.
- value = 16'hA0F8, dp_in = 4'b0100. Required: slot 0 = 00, slot 1 = 0E, slot 2 = 40 with dp = 0, slot 3 = 08. dp = 1 in all other slots.
- Change value from 16'h1111 to 16'h2222 mid-frame at digit_sel = 1. Required: the remaining slots of that frame still show 79. 24 appears only after the next frame_load. No single frame mixes the two values.
- Assert reset_n = 0 mid-SHOW of digit 2. Required: same-cycle segments = 7F, dp = 1, digit_sel = 0. After release, BLANK runs for 2 cycles, then 40 is shown.
- With LEADING_ZERO_BLANK_EN and value = 16'h0050: digits 3 and 2 show 7F, digit 1 = 12, digit 0 = 40. With value = 0: only digit 0 shows 40.
- Free-run for 3 frames. Required: frame_load pulses are exactly 32 cycles apart and each lasts 1 cycle.
